// File: rtl/mem_loader_if.sv
// Loader bus bundle: UART byte strobe in, datamemory write port and status out.
// Latency: none, wires only.
// Backpressure: none. rx_valid is a strobe, and the write port is fire-and-forget.
//
// Signals:
//   rx_valid/rx_data        byte strobe from the UART receiver
//   mem_write_en/addr/datain  datamemory write port
//   busy/done/err           frame status toward the processor
interface mem_loader_if #(
    parameter int N = 16
);
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         mem_write_en;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_datain;
    logic         busy;
    logic         done;
    logic         err;

    // master: the loader itself
    modport master (
        input  rx_valid, rx_data,
        output mem_write_en, mem_addr, mem_datain, busy, done, err
    );

    // slave: byte source plus memory/processor side
    modport slave (
        output rx_valid, rx_data,
        input  mem_write_en, mem_addr, mem_datain, busy, done, err
    );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream loader: parses ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT data bytes into datamemory writes.
// Latency: each data byte is written 1 cycle after it is accepted. done coincides with the last write.
// Backpressure: none. Every rx_valid strobe is accepted. An idle gap of TIMEOUT cycles inside a frame aborts it with err.
//
// Ports:
//   i_clk   system clock, posedge
//   i_rst   synchronous active-high reset
//   io_bus  mem_loader_if.master carrying the rx strobe, the datamemory write port, and busy/done/err
module mem_loader #(
    parameter int N       = 16,
    parameter int TIMEOUT = 50000000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_loader_if.master io_bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_base;
    logic [15:0]   r_cnt;
    logic [15:0]   r_idx;
    logic [TW-1:0] r_timer;

    logic          r_write_en;
    logic [N-1:0]  r_addr;
    logic [N-1:0]  r_datain;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_acc;
    logic          w_tmo;
    logic          w_cnt_zero;
    logic          w_last;
    logic [N-1:0]  w_addr_nxt;
    logic          w_write_en_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;
    logic          w_busy_nxt;

    assign w_acc      = io_bus.rx_valid;
    // A byte arriving on the would-be timeout cycle wins, so the timeout needs rx_valid low.
    assign w_tmo      = (r_state != S_ADDR_HI) && !w_acc && (r_timer == TW'(TIMEOUT - 1));
    assign w_cnt_zero = ({r_cnt[15:8], io_bus.rx_data} == 16'd0);
    assign w_last     = (r_idx == r_cnt - 16'd1);
    // Computed at memory width so the address wraps modulo 2^N.
    assign w_addr_nxt = N'(r_base) + N'(r_idx);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_ADDR_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo) begin
            w_state_nxt = S_ADDR_HI;
        end else if (w_acc) begin
            case (r_state)
                S_ADDR_HI: w_state_nxt = S_ADDR_LO;
                S_ADDR_LO: w_state_nxt = S_CNT_HI;
                S_CNT_HI:  w_state_nxt = S_CNT_LO;
                S_CNT_LO:  w_state_nxt = w_cnt_zero ? S_ADDR_HI : S_DATA;
                S_DATA:    w_state_nxt = w_last ? S_ADDR_HI : S_DATA;
                default:   w_state_nxt = S_ADDR_HI;
            endcase
        end
    end

    // Output decode. These are next-cycle values and are registered below.
    always_comb begin
        w_write_en_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = w_tmo;
        if (w_acc) begin
            case (r_state)
                S_CNT_LO: w_done_nxt = w_cnt_zero;
                S_DATA: begin
                    w_write_en_nxt = 1'b1;
                    w_done_nxt     = w_last;
                end
                default: ;
            endcase
        end
        // Busy covers every state except the idle header wait. It drops with done/err.
        w_busy_nxt = (w_state_nxt != S_ADDR_HI);
    end

    // Frame bookkeeping: header latches, data index, idle timer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            if (w_acc) begin
                case (r_state)
                    S_ADDR_HI: begin
                        r_base[15:8] <= io_bus.rx_data;
                        r_idx        <= '0;
                    end
                    S_ADDR_LO: r_base[7:0] <= io_bus.rx_data;
                    S_CNT_HI:  r_cnt[15:8] <= io_bus.rx_data;
                    S_CNT_LO:  r_cnt[7:0]  <= io_bus.rx_data;
                    S_DATA:    r_idx       <= r_idx + 16'd1;
                    default: ;
                endcase
            end
            if ((r_state == S_ADDR_HI) || w_acc || w_tmo) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Registered outputs. Address and data hold between writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_write_en <= 1'b0;
            r_addr     <= '0;
            r_datain   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_write_en <= w_write_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            if (w_write_en_nxt) begin
                r_addr   <= w_addr_nxt;
                r_datain <= N'(io_bus.rx_data);
            end
        end
    end

    assign io_bus.mem_write_en = r_write_en;
    assign io_bus.mem_addr     = r_addr;
    assign io_bus.mem_datain   = r_datain;
    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;
    assign io_bus.err          = r_err;
endmodule
